timing_config_ctrl: RTL
=======================

TIMING_CONFIG_CTRL -- requirements
Module: timing_config_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port wr_en, input, 1 bit: shadow register write strobe.
REQ-004 SHALL have port wr_addr, input, 4 bits: shadow register index.
REQ-005 SHALL have port wr_data, input, 23 bits: write data, LSB-aligned.
REQ-006 SHALL have port commit, input, 1 bit: request to transfer the shadow set to the active set.
REQ-007 SHALL have port abort, input, 1 bit: cancel a pending commit.
REQ-008 SHALL have port frame_start, input, 1 bit: one-cycle pulse from the timing generator at h_cnt=0, v_cnt=0.
REQ-009 SHALL have active parameter outputs (all registered): h_total [11:0], h_size [11:0], h_sync [10:0], h_start [10:0], v_total [10:0], v_size [10:0], v_sync [9:0], v_start [9:0], vs_reset [22:0].
REQ-010 SHALL have port gen_rst_n, output, 1 bit: active-low hold for the timing generator.
REQ-011 SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when the active set is updated.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse when a commit is rejected.

Function
REQ-014 SHALL use this address map: 0 h_total, 1 h_size, 2 h_sync, 3 h_start, 4 v_total, 5 v_size, 6 v_sync, 7 v_start, 8 vs_reset; addresses 9-15 ignored; each register takes wr_data LSBs truncated to its width.
REQ-015 SHALL accept writes only in IDLE; writes while busy are dropped and leave the shadow set unchanged.
REQ-016 SHALL implement FSM states IDLE, CHECK, WAIT_FRAME.
REQ-017 IDLE: commit=1 -> CHECK on next edge; commit outside IDLE ignored; wr_en and commit in the same cycle -> write lands first, then the commit checks the updated shadow set.
REQ-018 CHECK lasts exactly one cycle. On pass with gen_rst_n=0: load active set, done=1, gen_rst_n=1, -> IDLE. On pass with gen_rst_n=1: -> WAIT_FRAME. On fail: err=1, active set unchanged, -> IDLE.
REQ-019 WAIT_FRAME: on the edge sampling frame_start=1, active set <= shadow set, done=1, -> IDLE. frame_start outside WAIT_FRAME is ignored.
REQ-020 WAIT_FRAME with abort=1: -> IDLE, no update, no done/err. abort and frame_start both high: abort wins.
REQ-021 All active outputs SHALL update on the same edge; no partial set is ever visible.
REQ-022 Latency: commit edge N -> CHECK N+1 -> WAIT_FRAME from N+2; active update on the first frame_start sampled at or after N+2. First load (generator held) completes at N+2.
REQ-023 Shadow contents SHALL persist across commits, errors and aborts.

Reset
REQ-024 rst_n low asynchronously SHALL force: state IDLE; shadow and active registers all zero; gen_rst_n=0; busy=0; done=0; err=0.
REQ-025 gen_rst_n SHALL stay 0 after reset until the first passing commit, then remain 1 until the next reset.
REQ-026 Reset during WAIT_FRAME SHALL discard the pending commit.

Configuration
REQ-027 Macro TCFG_CHECK_EN defined: CHECK passes only if h_total>=2, v_total>=2, h_sync<h_total, v_sync<v_total, h_start+h_size<=h_total (13-bit sum), and v_start+v_size<=v_total (12-bit sum).
REQ-028 Macro TCFG_CHECK_EN undefined: CHECK always passes, err is tied 0, and CHECK still costs one cycle.

Verification
REQ-029 Reset, write 1080p set (2200/1920/44/192/1125/1080/5/41/0), commit -> done at commit+2, gen_rst_n rises same edge, outputs equal set.
REQ-030 After REQ-029, write h_total=2000, commit, frame_start 10 cycles later -> h_total stays 2200 until the frame_start edge, then 2000 with done.
REQ-031 With TCFG_CHECK_EN: h_start=192, h_size=2100, h_total=2200, commit -> err pulse, outputs unchanged, busy low after 2 cycles.
REQ-032 WAIT_FRAME, abort and frame_start asserted together -> no done, outputs unchanged, IDLE next.
REQ-033 wr_en to addr 0 during WAIT_FRAME -> shadow unchanged; a later frame_start applies the pre-commit value.
REQ-034 rst_n pulsed low in WAIT_FRAME -> all outputs 0, gen_rst_n=0 immediately, no done.

Source files
------------

// File: rtl/timing_config_ctrl.sv
// rtl/timing_config_ctrl.sv - shadow/active video timing register set with frame-synchronous commit
// Optional consistency check of the shadow set before commit: define TCFG_CHECK_EN.
module timing_config_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [22:0] wr_data,
    input  logic        commit,
    input  logic        abort,
    input  logic        frame_start,
    output logic [11:0] h_total,
    output logic [11:0] h_size,
    output logic [10:0] h_sync,
    output logic [10:0] h_start,
    output logic [10:0] v_total,
    output logic [10:0] v_size,
    output logic [9:0]  v_sync,
    output logic [9:0]  v_start,
    output logic [22:0] vs_reset,
    output logic        gen_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CHECK      = 2'd1,
        WAIT_FRAME = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [11:0] sh_h_total;
    logic [11:0] sh_h_size;
    logic [10:0] sh_h_sync;
    logic [10:0] sh_h_start;
    logic [10:0] sh_v_total;
    logic [10:0] sh_v_size;
    logic [9:0]  sh_v_sync;
    logic [9:0]  sh_v_start;
    logic [22:0] sh_vs_reset;

    logic load_active;
    logic done_nxt;
    logic cfg_ok;

    // Shadow set only accepts host writes while no commit is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_h_total  <= '0;
            sh_h_size   <= '0;
            sh_h_sync   <= '0;
            sh_h_start  <= '0;
            sh_v_total  <= '0;
            sh_v_size   <= '0;
            sh_v_sync   <= '0;
            sh_v_start  <= '0;
            sh_vs_reset <= '0;
        end else if (wr_en && state == IDLE) begin
            case (wr_addr)
                4'd0:    sh_h_total  <= wr_data[11:0];
                4'd1:    sh_h_size   <= wr_data[11:0];
                4'd2:    sh_h_sync   <= wr_data[10:0];
                4'd3:    sh_h_start  <= wr_data[10:0];
                4'd4:    sh_v_total  <= wr_data[10:0];
                4'd5:    sh_v_size   <= wr_data[10:0];
                4'd6:    sh_v_sync   <= wr_data[9:0];
                4'd7:    sh_v_start  <= wr_data[9:0];
                4'd8:    sh_vs_reset <= wr_data;
                default: ;
            endcase
        end
    end

`ifdef TCFG_CHECK_EN
    logic [12:0] h_end;
    logic [11:0] v_end;

    assign h_end  = {2'b00, sh_h_start} + {1'b0, sh_h_size};
    assign v_end  = {2'b00, sh_v_start} + {1'b0, sh_v_size};
    assign cfg_ok = (sh_h_total >= 12'd2) && (sh_v_total >= 11'd2) &&
                    ({1'b0, sh_h_sync} < sh_h_total) &&
                    ({1'b0, sh_v_sync} < sh_v_total) &&
                    (h_end <= {1'b0, sh_h_total}) &&
                    (v_end <= {1'b0, sh_v_total});
`else
    assign cfg_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_active = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!cfg_ok) begin
                    state_nxt = IDLE;
                end else if (!gen_rst_n) begin
                    // Generator is still held, so nothing is being scanned out: load at once.
                    load_active = 1'b1;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    state_nxt = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (frame_start) begin
                    load_active = 1'b1;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The whole active set moves on one edge so the generator never sees a mixed set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_total   <= '0;
            h_size    <= '0;
            h_sync    <= '0;
            h_start   <= '0;
            v_total   <= '0;
            v_size    <= '0;
            v_sync    <= '0;
            v_start   <= '0;
            vs_reset  <= '0;
            gen_rst_n <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_nxt;
            if (load_active) begin
                h_total   <= sh_h_total;
                h_size    <= sh_h_size;
                h_sync    <= sh_h_sync;
                h_start   <= sh_h_start;
                v_total   <= sh_v_total;
                v_size    <= sh_v_size;
                v_sync    <= sh_v_sync;
                v_start   <= sh_v_start;
                vs_reset  <= sh_vs_reset;
                gen_rst_n <= 1'b1;
            end
        end
    end

`ifdef TCFG_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= (state == CHECK) && !cfg_ok;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule
